// File: rtl/apb_timer_pkg.sv
// Shared register offsets and CTRL bit positions for the APB timer.
package apb_timer_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_LOAD    = 3'd1;
    localparam logic [2:0] ADDR_VALUE   = 3'd2;
    localparam logic [2:0] ADDR_INTSTAT = 3'd3;
    localparam logic [2:0] ADDR_PRESC   = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;

    // Offsets 5..7 decode to nothing.
    function automatic logic addr_mapped(input logic [2:0] a);
        return a <= ADDR_PRESC;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the bridge and the timer.
// PREADY/PSLVERR exist only when APB_TIMER_APB3_EN is defined.
interface apb_timer_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
`ifdef APB_TIMER_APB3_EN
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
`else
    modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    input  PRDATA);
    modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    output PRDATA);
`endif
endinterface

// File: rtl/apb_timer_core.sv
// Prescaler plus 32-bit down-counter with periodic reload or one-shot stop.
module apb_timer_core #(
    parameter int DATAWIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   oneshot,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic [DATAWIDTH-1:0]   load_val,
    input  logic                   load_wr,
    output logic [DATAWIDTH-1:0]   value,
    output logic                   expire,
    output logic                   en_clr
);

    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic                   tick;

    // Compare against the live PRESC so a rewrite applies on the next compare.
    assign tick   = en && (presc_cnt == presc);
    assign expire = tick && (value == '0);
    assign en_clr = expire && oneshot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_cnt <= '0;
        else if (!en || tick)
            presc_cnt <= '0;
        else
            presc_cnt <= presc_cnt + 1'b1;
    end

    // A LOAD write beats any decrement or reload on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (load_wr)
            value <= load_val;
        else if (tick) begin
            if (value != '0)
                value <= value - 1'b1;
            else if (!oneshot)
                value <= load_val;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB timer top: bus decode, register file, sticky RAWINT and registered read mux.
// Optional APB3 PREADY/PSLVERR signalling is enabled with `define APB_TIMER_APB3_EN.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic      PCLK,
    input  logic      PRESETn,
    apb_timer_if.slave apb,
    output logic      TIMERINT
);

    logic [2:0]             addr;
    logic                   wr_en;
    logic                   rd_setup;
    logic [2:0]             ctrl_q;
    logic [DATAWIDTH-1:0]   load_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic                   rawint;
    logic [DATAWIDTH-1:0]   value;
    logic                   expire;
    logic                   en_clr;
    logic                   load_wr;
    logic [DATAWIDTH-1:0]   rdata;
    logic                   unused_addr;

    assign addr        = apb.PADDR[4:2];
    assign unused_addr = ^{apb.PADDR[ADDRWIDTH-1:5], apb.PADDR[1:0]};
    assign rd_setup    = apb.PSEL && !apb.PENABLE && !apb.PWRITE;

`ifdef APB_TIMER_APB3_EN
    logic bad_acc;
    assign bad_acc     = !addr_mapped(addr) || (apb.PWRITE && addr == ADDR_VALUE);
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL && apb.PENABLE && bad_acc;
    assign wr_en       = apb.PSEL && apb.PENABLE && apb.PWRITE && !bad_acc;
`else
    assign wr_en       = apb.PSEL && apb.PENABLE && apb.PWRITE;
`endif

    assign load_wr  = wr_en && (addr == ADDR_LOAD);
    assign TIMERINT = rawint & ctrl_q[CTRL_IE];

    apb_timer_core #(
        .DATAWIDTH  (DATAWIDTH),
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_core (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .en      (ctrl_q[CTRL_EN]),
        .oneshot (ctrl_q[CTRL_ONESHOT]),
        .presc   (presc_q),
        .load_val(load_wr ? apb.PWDATA : load_q),
        .load_wr (load_wr),
        .value   (value),
        .expire  (expire),
        .en_clr  (en_clr)
    );

    // Software CTRL write wins over the one-shot hardware clear of EN.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            ctrl_q <= '0;
        else if (wr_en && addr == ADDR_CTRL)
            ctrl_q <= apb.PWDATA[2:0];
        else if (en_clr)
            ctrl_q[CTRL_EN] <= 1'b0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            load_q  <= '0;
            presc_q <= '0;
        end else begin
            if (load_wr)
                load_q <= apb.PWDATA;
            if (wr_en && addr == ADDR_PRESC)
                presc_q <= apb.PWDATA[PRESC_WIDTH-1:0];
        end
    end

    // Expiry set outranks a same-edge W1C so no interrupt is lost.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            rawint <= 1'b0;
        else if (expire)
            rawint <= 1'b1;
        else if (wr_en && addr == ADDR_INTSTAT && apb.PWDATA[0])
            rawint <= 1'b0;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:    rdata = DATAWIDTH'(ctrl_q);
            ADDR_LOAD:    rdata = load_q;
            ADDR_VALUE:   rdata = value;
            ADDR_INTSTAT: rdata = DATAWIDTH'(rawint);
            ADDR_PRESC:   rdata = DATAWIDTH'(presc_q);
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            apb.PRDATA <= '0;
        else
            apb.PRDATA <= rd_setup ? rdata : '0;
    end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_apb_timer;

    localparam logic [15:0] A_CTRL  = 16'h00;
    localparam logic [15:0] A_LOAD  = 16'h04;
    localparam logic [15:0] A_VALUE = 16'h08;
    localparam logic [15:0] A_INT   = 16'h0C;
    localparam logic [15:0] A_PRESC = 16'h10;
    localparam logic [15:0] A_UNM5  = 16'h14;
    localparam logic [15:0] A_UNM7  = 16'h1C;

    logic PCLK = 1'b0;
    logic PRESETn;
    logic TIMERINT;
    logic chk_int = 1'b0;

    apb_timer_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

    apb_timer #(.ADDRWIDTH(16), .DATAWIDTH(32), .PRESC_WIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
        .TIMERINT(TIMERINT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t int_q[$];
    logic err_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (bus.PSEL && bus.PENABLE) begin
`ifdef APB_TIMER_APB3_EN
                if (err_q.size() == 0) begin
                    failures++;
                    $display("FAIL err_q_empty at %0t", $time);
                end else begin
                    logic e;
                    e = err_q.pop_front();
                    check("pslverr", 32'(bus.PSLVERR), 32'(e));
                    check("pready", 32'(bus.PREADY), 32'd1);
                end
`endif
                if (!bus.PWRITE) begin
                    if (rd_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_read at %0t", $time);
                    end else begin
                        exp_t r;
                        r = rd_q.pop_front();
                        check(r.name, bus.PRDATA, r.exp);
                    end
                end
            end
            if (chk_int) begin
                if (int_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_int_check at %0t", $time);
                end else begin
                    exp_t r;
                    r = int_q.pop_front();
                    check(r.name, 32'(TIMERINT), r.exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = a;
        bus.PWDATA  = d;
`ifdef APB_TIMER_APB3_EN
        err_q.push_back((a[4:2] > 3'd4) || (wr && a[4:2] == 3'd2));
`endif
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        apb_xfer(1'b1, a, d);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        apb_xfer(1'b0, a, 32'h0);
    endtask

    task automatic chk_tint(input string name, input logic exp);
        exp_t e;
        e.name = name;
        e.exp  = 32'(exp);
        int_q.push_back(e);
        chk_int = 1'b1;
        @(posedge PCLK); #1;
        chk_int = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Reset state of every register, then CTRL read-back
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_load", A_LOAD, 32'h0);
        rd("rst_value", A_VALUE, 32'h0);
        rd("rst_intstat", A_INT, 32'h0);
        rd("rst_presc", A_PRESC, 32'h0);
        rd("rst_unmapped", A_UNM7, 32'h0);
        chk_tint("rst_timerint", 1'b0);
        wr(A_CTRL, 32'h3);
        rd("ctrl_readback", A_CTRL, 32'h3);
        wr(A_CTRL, 32'h0);
        wr(A_INT, 32'h1);
        rd("w1c_after_ctrl", A_INT, 32'h0);
        wr(A_UNM5, 32'hFFFF_FFFF);
        rd("unmapped_write_ignored", A_UNM5, 32'h0);

        // Periodic, LOAD=3, PRESC=0: expiries at Ec+4, +8, +12 ...
        wr(A_LOAD, 32'h3);
        wr(A_PRESC, 32'h0);
        wr(A_CTRL, 32'h3);
        rd("per_value_0", A_VALUE, 32'd3);
        idle(1);
        rd("per_value_3", A_VALUE, 32'd0);
        rd("per_value_5", A_VALUE, 32'd2);
        chk_tint("per_timerint_set", 1'b1);
        rd("per_intstat", A_INT, 32'h1);
        idle(1);
        wr(A_INT, 32'h1);
        chk_tint("per_w1c_drops", 1'b0);
        // W1C lands on the Ec+16 expiry edge
        wr(A_INT, 32'h1);
        rd("set_beats_w1c", A_INT, 32'h1);
        // LOAD write lands on the Ec+20 expiry edge
        wr(A_LOAD, 32'd9);
        rd("load_beats_reload", A_VALUE, 32'd9);
        wr(A_CTRL, 32'h2);
        chk_tint("ie_only_int", 1'b1);
        wr(A_CTRL, 32'h0);
        chk_tint("ie_masked", 1'b0);
        rd("masked_rawint_kept", A_INT, 32'h1);
        wr(A_INT, 32'h1);
        rd("rawint_cleared", A_INT, 32'h0);

        // Prescaled: LOAD=1, PRESC=4, ticks at Ec+5, +10, ...
        wr(A_PRESC, 32'h4);
        wr(A_LOAD, 32'h1);
        wr(A_CTRL, 32'h3);
        rd("psc_value_0", A_VALUE, 32'd1);
        idle(2);
        rd("psc_value_4", A_VALUE, 32'd1);
        rd("psc_value_6", A_VALUE, 32'd0);
        rd("psc_int_before", A_INT, 32'h0);
        rd("psc_int_at10", A_INT, 32'h1);
        rd("psc_reloaded", A_VALUE, 32'd1);
        rd("psc_presc", A_PRESC, 32'h4);
        wr(A_CTRL, 32'h0);
        wr(A_INT, 32'h1);
        wr(A_PRESC, 32'h0);

        // One-shot: LOAD=2, expiry at Ec+3 clears EN
        wr(A_LOAD, 32'h2);
        wr(A_CTRL, 32'h7);
        rd("os_ctrl_run", A_CTRL, 32'h7);
        idle(2);
        rd("os_ctrl_done", A_CTRL, 32'h6);
        rd("os_value", A_VALUE, 32'h0);
        chk_tint("os_timerint", 1'b1);
        wr(A_INT, 32'h1);
        idle(10);
        rd("os_no_reint", A_INT, 32'h0);
        rd("os_value_hold", A_VALUE, 32'h0);

        // CTRL write on the one-shot expiry edge keeps EN
        wr(A_LOAD, 32'h2);
        wr(A_CTRL, 32'h5);
        idle(1);
        wr(A_CTRL, 32'h5);
        rd("ctrl_beats_en_clr", A_CTRL, 32'h5);
        wr(A_CTRL, 32'h0);
        wr(A_INT, 32'h1);

        // Asynchronous reset mid-run
        wr(A_LOAD, 32'h1);
        wr(A_CTRL, 32'h3);
        idle(3);
        chk_tint("pre_reset_int", 1'b1);
        PRESETn = 1'b0;
        idle(1);
        PRESETn = 1'b1;
        chk_tint("post_reset_int", 1'b0);
        rd("post_reset_ctrl", A_CTRL, 32'h0);
        rd("post_reset_load", A_LOAD, 32'h0);
        rd("post_reset_value", A_VALUE, 32'h0);

`ifdef APB_TIMER_APB3_EN
        wr(A_LOAD, 32'h7);
        wr(A_VALUE, 32'h55);
        rd("apb3_value_kept", A_VALUE, 32'h7);
        rd("apb3_unmapped_rd", A_UNM5, 32'h0);
`endif

        idle(2);
        if (rd_q.size() != 0 || int_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations actual=%0d required=0", rd_q.size() + int_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- APB slave peripheral on the APB side of the AHB-to-APB bridge; consumes the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA.
- 32-bit down-counting timer with programmable prescaler, periodic and one-shot modes, and a maskable, sticky interrupt.
- Clocked by the same clock the bridge gates with PCLKEN. The subsystem supplies it as PCLK.

Parameters:
- ADDRWIDTH, 16, width of PADDR. Only PADDR[4:2] is decoded; upper bits are decoded upstream.
- DATAWIDTH, 32, APB data width. Counter and LOAD widths equal DATAWIDTH.
- PRESC_WIDTH, 8, prescaler register and counter width.

Ports:
- PCLK  in  1  clock. Single clock domain.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  ADDRWIDTH  APB address (byte address, word aligned).
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATAWIDTH  write data.
- PRDATA  out  DATAWIDTH  read data, registered.
- TIMERINT  out  1  interrupt, active high, level.
- PREADY  out  1  only with APB_TIMER_APB3_EN.
- PSLVERR  out  1  only with APB_TIMER_APB3_EN.

Behaviour:
- Register map (PADDR[4:2]):
  - 0 CTRL: RW. Bit 0 EN, bit 1 IE, bit 2 ONESHOT. Other bits read 0.
  - 1 LOAD: RW.
  - 2 VALUE: RO.
  - 3 INTSTAT: bit 0 RAWINT. Write 1 to clear; read.
  - 4 PRESC: RW, PRESC_WIDTH bits, zero-extended on read.
  - 5..7: unmapped. Reads return 0; writes are ignored.
- Reset: all registers, counters, PRDATA and TIMERINT are 0. PREADY is 1 and PSLVERR is 0 when present.
- Write strobe: PSEL & PENABLE & PWRITE. The register updates on that edge. There is no byte-lane masking; writes are full word.
- Read: on a setup cycle (PSEL & ~PENABLE & ~PWRITE), the muxed register value is registered into PRDATA. PRDATA holds that value through the access phase.
  - PRDATA is 0 on any cycle without a read setup.
  - VALUE reads return the count at the setup-cycle edge.
- Writing LOAD also writes VALUE on the same edge. This overrides any decrement or reload in that cycle.
- Prescaler:
  - presc_cnt increments while EN=1.
  - When presc_cnt == PRESC, a tick is generated and presc_cnt returns to 0.
  - presc_cnt is forced to 0 while EN=0.
  - PRESC=0 gives a tick every cycle.
- Counting on a tick:
  - If VALUE != 0: VALUE <= VALUE-1.
  - If VALUE == 0: RAWINT <= 1.
    - Periodic mode (ONESHOT=0): VALUE <= LOAD.
    - One-shot mode (ONESHOT=1): VALUE stays 0 and EN is cleared by hardware.
- Period is (LOAD+1)*(PRESC+1) PCLK cycles. LOAD=0 in periodic mode sets RAWINT on every tick.
- Simultaneous events:
  - A RAWINT set and a W1C on the same edge: the set wins.
  - A CTRL write on the same edge that hardware clears EN: the CTRL write wins.
- TIMERINT = RAWINT & IE, from flops with no combinational path from APB inputs. Clearing IE masks the output but keeps RAWINT.
- Writing PRESC while running takes effect on the next presc_cnt comparison. presc_cnt is not reset by this write.
- Asserting PRESETn mid-operation returns everything to reset values immediately. There is no pending state.

Optional Feature:
- Macro: APB_TIMER_APB3_EN.
- Defined:
  - PREADY and PSLVERR ports exist. PREADY is tied to 1 (zero wait states).
  - PSLVERR = PSEL & PENABLE & (unmapped address, or write to VALUE). It is combinational and valid only in the access phase.
  - Errored writes do not modify state.
- Undefined:
  - The ports are absent. Those accesses complete silently: writes are ignored and unmapped reads return 0.

Decomposition:
- Package apb_timer_pkg holds:
  - Register offset constants: ADDR_CTRL=3'd0, ADDR_LOAD=3'd1, ADDR_VALUE=3'd2, ADDR_INTSTAT=3'd3, ADDR_PRESC=3'd4.
  - CTRL bit indices: CTRL_EN=0, CTRL_IE=1, CTRL_ONESHOT=2.
- Sub-module apb_timer_core holds the prescaler, down-counter and reload/one-shot logic.
  - Inputs: en, oneshot, presc, load_val, load_wr.
  - Outputs: value, expire pulse, en_clr pulse.
- The top level holds the APB decode, the register file, RAWINT and the read mux.

Test Plan:
- Reset, then read all five offsets → all return 0 and TIMERINT=0. Write CTRL=0x3 and read it back → 0x3.
- LOAD=3, PRESC=0, CTRL=0x3 (periodic, IE) → VALUE counts 3,2,1,0,3. RAWINT sets every 4 cycles. W1C INTSTAT=1 drops TIMERINT next cycle.
- LOAD=1, PRESC=4, CTRL=0x3 → first RAWINT 10 cycles after enable. VALUE changes only every 5 cycles.
- LOAD=2, CTRL=0x7 (one-shot) → RAWINT once after 3 ticks, VALUE stays 0, CTRL reads 0x6, no further interrupts.
- Time a W1C of INTSTAT on the same edge as expiry → RAWINT reads 1 afterwards. A LOAD write at an expiry edge → VALUE equals the written value.
- With APB_TIMER_APB3_EN: write to 0x08 and read from 0x14 → PSLVERR=1 in the access phase, PREADY=1, VALUE unchanged, PRDATA=0.
